rs_alu_seq_ctrl: RTL and testbench
==================================

Name: rs_alu_seq_ctrl

Overview:
- Multi-cycle sequencer that computes wide add/subtract on a single narrow carry-chain slice adder.
- The slice is SLICE_W bits, built from the adder_carry primitive.
- A WIDTH-bit operation runs LSB slice first, one slice per cycle. The carry between slices is held in a register.
- Used where a full-width carry chain is too costly in area or routing. Sits between a requesting datapath and the shared slice adder, with valid/ready on both sides.

Parameters:
- WIDTH, 64: operand/result width. Must be a multiple of SLICE_W.
- SLICE_W, 16: bits added per cycle (carry-chain length of the slice adder).
- NSLICE, WIDTH/SLICE_W: derived number of slices. Not overridable. NSLICE==1 is legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- op_sub  in  1  0: add; 1: subtract.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  add: carry-in; sub: borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- co  out  1  final carry out (sub: 1 = no borrow).
- ov  out  1  signed overflow.
- zero  out  1  y == 0.
- busy  out  1  operation in progress (state RUN).

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1 (first cycle after reset), out_valid=0, busy=0, y=0, co=0, ov=0, zero=0. Slice index and carry register are cleared.
- States:
  - IDLE: in_ready=1. On in_valid, capture a, b, op_sub and carry0 = op_sub ? ~ci : ci. Go to RUN with idx=0.
  - RUN: in_ready=0, busy=1. Each cycle compute sum = a[idx] + (op_sub ? ~b[idx] : b[idx]) + carry, slice-wise. Write sum into y[idx*SLICE_W +: SLICE_W] and the slice carry-out into the carry register. idx wraps/terminates at NSLICE-1, then go to DONE.
  - DONE: out_valid=1, in_ready=0. y/co/ov/zero are stable. On out_ready, go to IDLE next cycle with out_valid=0.
- Latency: request accepted at edge T; slice i is processed in cycle T+1+i; out_valid rises at T+1+NSLICE. Throughput is one op per NSLICE+2 cycles.
- Subtract semantics: y = a - b - ci (mod 2^WIDTH).
- Flags:
  - co = carry out of the MSB of the last slice.
  - ov = carry-into-MSB XOR carry-out-of-MSB, from the last slice only.
  - zero is registered with y in DONE.
- Outputs y/co/ov/zero hold their previous values while in IDLE/RUN. Consumers sample them only when out_valid=1.
- Operand capture: a/b/op_sub/ci may change after acceptance without effect.
- in_valid while not in IDLE is ignored (no queueing). A requester must hold in_valid until handshake.
- out_ready while out_valid=0 is ignored.
- Reset asserted in RUN or DONE aborts immediately. The next cycle is IDLE with all reset values, and the partial result is discarded.
- Carry wrap: the carry register is reloaded from carry0 at every accept. There is no carry leakage between operations.

Decomposition:
- Package rs_alu_seq_pkg holds:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding;
  - op encoding constants OP_ADD=0, OP_SUB=1;
  - a helper function for the slice count.
- Sub-module rs_alu_slice: combinational SLICE_W adder (inputs a, b, bi, cin; outputs sum, cout, c_msb_in) built from a chain of adder_carry cells. The controller owns all state; the slice has none.

Test Plan:
Use WIDTH=64, SLICE_W=16.
1. Simple add: a=5, b=3, op_sub=0, ci=0 → y=8, co=0, ov=0, zero=0. out_valid exactly 5 cycles after accept.
2. Cross-slice carry: a=64'h0000_0000_0000_FFFF, b=1, add → y=64'h1_0000. Then a=all-ones, b=1 → y=0, co=1, zero=1.
3. Subtract/borrow: a=5, b=3, sub, ci=0 → y=2, co=1. Then a=3, b=5, sub → y=64'hFFFF_FFFF_FFFF_FFFE, co=0. Then a=5, b=3, sub, ci=1 → y=1.
4. Overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, add → y=64'h8000_0000_0000_0000, ov=1, co=0.
5. Handshake:
   - Hold out_ready=0 for 10 cycles → out_valid and y stay stable, in_ready=0, and a second in_valid is ignored.
   - Release out_ready → IDLE next cycle, then the second request is accepted.
6. Reset mid-RUN: assert rst at slice 2 → next cycle in_ready=1, out_valid=0, y=0. A fresh 1+1 then returns y=2.

Source files
------------

// File: rtl/rs_alu_seq_pkg.sv
// Shared types and helpers for the sliced add/subtract sequencer.
package rs_alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of slice passes needed to cover a full operand.
  function automatic int sliceCount(input int width, input int sliceW);
    return width / sliceW;
  endfunction

endpackage

// File: rtl/rs_alu_slice.sv
// Narrow ripple-carry slice adder and its one-bit carry cell.
// The slice is purely combinational; the controller owns all state.
module adder_carry (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module rs_alu_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb_in
);

  logic [SLICE_W-1:0] w_bEff;
  logic [SLICE_W:0]   w_carry;

  // bi inverts B so that subtraction becomes A + ~B + carry.
  assign w_bEff     = b ^ {SLICE_W{bi}};
  assign w_carry[0] = cin;

  for (genvar g = 0; g < SLICE_W; g++) begin : g_chain
    adder_carry u_cell (
      .a  (a[g]),
      .b  (w_bEff[g]),
      .ci (w_carry[g]),
      .s  (sum[g]),
      .co (w_carry[g+1])
    );
  end

  assign cout     = w_carry[SLICE_W];
  assign c_msb_in = w_carry[SLICE_W-1];

endmodule

// File: rtl/rs_alu_seq_ctrl.sv
// Sequencer that performs a WIDTH-bit add/subtract one SLICE_W slice per
// cycle on a shared narrow adder, LSB slice first, with valid/ready handshakes.
module rs_alu_seq_ctrl
  import rs_alu_seq_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SLICE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ov,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = sliceCount(WIDTH, SLICE_W);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             r_state;
  state_t             w_nextState;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_opSub;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_y;
  logic               r_co;
  logic               r_ov;
  logic               r_zero;

  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic               w_cMsbIn;
  logic               w_lastSlice;
  logic [WIDTH-1:0]   w_sumExt;
  logic [WIDTH-1:0]   w_yNext;

  // Operands are shifted right each cycle, so the active slice is always the low bits.
  rs_alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a        (r_a[SLICE_W-1:0]),
    .b        (r_b[SLICE_W-1:0]),
    .bi       (r_opSub == OP_SUB),
    .cin      (r_carry),
    .sum      (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_cMsbIn)
  );

  assign w_lastSlice = (r_idx == IDX_W'(NSLICE - 1));
  assign w_sumExt    = WIDTH'(w_sum);
  // New slice enters at the top; after NSLICE passes the result sits in order.
  assign w_yNext     = (r_acc >> SLICE_W) | (w_sumExt << (WIDTH - SLICE_W));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastSlice) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation, and result/flag commit on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_opSub <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_opSub <= op_sub;
            r_carry <= (op_sub == OP_SUB) ? ~ci : ci;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_acc   <= w_yNext;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_lastSlice) begin
            r_y    <= w_yNext;
            r_co   <= w_cout;
            r_ov   <= w_cMsbIn ^ w_cout;
            r_zero <= (w_yNext == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign y    = r_y;
  assign co   = r_co;
  assign ov   = r_ov;
  assign zero = r_zero;

endmodule

// File: tb/tb_rs_alu_seq_ctrl.sv
// Directed, table-driven bench for the sliced add/subtract sequencer.
module tb_rs_alu_seq_ctrl;

  localparam int WIDTH   = 64;
  localparam int SLICE_W = 16;
  localparam int NSLICE  = WIDTH / SLICE_W;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             ov;
  logic             zero;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string            name;
    logic             opSub;
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vci;
    logic [WIDTH-1:0] expY;
    logic             expCo;
    logic             expOv;
    logic             expZero;
  } vec_t;

  vec_t vecs[$];

  rs_alu_seq_ctrl #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .co        (co),
    .ov        (ov),
    .zero      (zero),
    .busy      (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launches one request, scrambles inputs after acceptance, and waits for out_valid.
  task automatic applyStimulus(input logic opS, input logic [WIDTH-1:0] va,
                               input logic [WIDTH-1:0] vb, input logic vci,
                               output int lat);
    int n;
    @(negedge clk);
    op_sub   = opS;
    a        = va;
    b        = vb;
    ci       = vci;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    op_sub   = ~opS;
    ci       = ~vci;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("releaseOutValid", 64'(out_valid), 64'd0);
    checkOutput("releaseInReady", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int n;

    vecs.push_back('{"add5p3",   1'b0, 64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"carry16",  1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                     64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"onesP1",   1'b0, {64{1'b1}}, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"noLeak",   1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"addCi",    1'b0, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sub5m3",   1'b1, 64'd5, 64'd3, 1'b0, 64'd2, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sub3m5",   1'b1, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE,
                     1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sub5m3b",  1'b1, 64'd5, 64'd3, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sub0m0",   1'b1, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{"ovAdd",    1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"ovSub",    1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0});

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rstInReady", 64'(in_ready), 64'd1);
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstY", y, 64'd0);
    checkOutput("rstFlags", {60'd0, co, ov, zero, 1'b0}, 64'd0);

    // Table-driven arithmetic vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].opSub, vecs[i].va, vecs[i].vb, vecs[i].vci, lat);
      checkOutput({vecs[i].name, "_lat"}, 64'(lat), 64'(NSLICE + 1));
      checkOutput({vecs[i].name, "_y"}, y, vecs[i].expY);
      checkOutput({vecs[i].name, "_co"}, 64'(co), 64'(vecs[i].expCo));
      checkOutput({vecs[i].name, "_ov"}, 64'(ov), 64'(vecs[i].expOv));
      checkOutput({vecs[i].name, "_zero"}, 64'(zero), 64'(vecs[i].expZero));
      checkOutput({vecs[i].name, "_inReady"}, 64'(in_ready), 64'd0);
      releaseResult();
    end

    // Back-pressure: result must hold and a second request must wait.
    applyStimulus(1'b0, 64'd10, 64'd20, 1'b0, lat);
    @(negedge clk);
    op_sub   = 1'b0;
    a        = 64'd100;
    b        = 64'd1;
    ci       = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checkOutput("holdOutValid", 64'(out_valid), 64'd1);
      checkOutput("holdY", y, 64'd30);
      checkOutput("holdInReady", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("hsIdleOutValid", 64'(out_valid), 64'd0);
    checkOutput("hsIdleInReady", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("hsSecondBusy", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hsSecondY", y, 64'd101);
    releaseResult();

    // Reset during RUN aborts the operation.
    @(negedge clk);
    op_sub   = 1'b0;
    a        = 64'h1234_5678_9ABC_DEF0;
    b        = 64'h1111_1111_1111_1111;
    ci       = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midRunBusy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortInReady", 64'(in_ready), 64'd1);
    checkOutput("abortOutValid", 64'(out_valid), 64'd0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortY", y, 64'd0);
    applyStimulus(1'b0, 64'd1, 64'd1, 1'b0, lat);
    checkOutput("afterAbortLat", 64'(lat), 64'(NSLICE + 1));
    checkOutput("afterAbortY", y, 64'd2);
    releaseResult();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
